la_checkbit_sequencer: RTL and testbench
========================================

Name: la_checkbit_sequencer

Overview:
- User-project block driven by the management SoC through the logic analyzer (LA) bank.
- Firmware pushes 16-bit check words using a toggle handshake. The block buffers them in an 8-entry FIFO and presents each word on mprj_io[31:16] for a programmable number of clocks.
- It is the stage directly upstream of the bench monitor that waits on checkbits (for example 0xAB40 → 0xAB41 → 0xAB51).
- Status is returned to firmware on la_data_out.

Parameters:
- DEPTH, 8, FIFO entries (power of two, 2..16)
- WORD_W, 16, check word width

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  synchronous, active-high reset
- la_data_in  in  32  [15:0] word, [16] req toggle, [24:17] hold count, [25] enable, [26] clear
- la_oenb  in  32  a field is honoured only when its la_oenb bits are 0; otherwise that field reads as 0
- la_data_out  out  32  [15:0] displayed word, [16] ack toggle, [20:17] FIFO level, [21] overflow (sticky), [22] busy, [31:23] 0
- io_out  out  16  displayed word, to mprj_io[31:16]
- io_oeb  out  16  output enables, active low

Behaviour:
- Reset values (any cycle with wb_rst_i=1, including mid-operation):
  - io_out=0, io_oeb=16'hFFFF, la_data_out=0
  - FIFO empty, FSM in IDLE, hold counter 0, input registers 0
- After reset deasserts, io_oeb=16'h0000 from the next cycle onward.
- Input stage:
  - la_data_in is masked by ~la_oenb and registered (stage R).
  - req_prev holds the previous R.req.
  - A push request is R.req != req_prev.
- Push (same cycle the request is detected):
  - If level < DEPTH: write R.word at wr_ptr, increment wr_ptr and level, toggle ack. ack becomes visible 2 cycles after the req toggle is applied on la_data_in.
  - If level == DEPTH: drop the word, set overflow, leave ack unchanged. Firmware retries.
  - Full check uses the level at cycle start. A push arriving when full is rejected even if a pop happens in the same cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. level is log2(DEPTH)+1 bits; it is reported on [20:17], zero-extended or truncated to 4 bits.
- Drain FSM, states IDLE and HOLD:
  - IDLE → HOLD when R.enable=1 and level>0 (level at cycle start):
    - pop: io_out ← head word, increment rd_ptr, decrement level
    - load hold_cnt ← max(R.hold,1)−1
  - HOLD: decrement hold_cnt each cycle; at 0 → IDLE.
  - Each word is therefore displayed for max(hold,1)+1 cycles before the next pop can occur. With hold=0 the back-to-back pop interval is 2 cycles.
  - enable=0 in HOLD: the countdown continues, but no new pop occurs in IDLE.
  - io_out keeps the last popped word indefinitely.
- Simultaneous push and pop in one cycle: level is unchanged, both pointers advance.
- Push into an empty FIFO with enable=1: the word reaches io_out 1 cycle after level becomes 1.
- busy = (state==HOLD) | (level!=0).
- clear (R.clear=1):
  - flushes the FIFO (pointers and level to 0) and clears overflow
  - ack, io_out and FSM state are not altered
  - takes priority over a push in the same cycle; that push is dropped without setting overflow
- la_data_out[15:0] mirrors io_out.
- All outputs are registered.

Test Plan:
- Reset, enable=1, hold=4, push 0xAB40 → ack toggles 2 cycles after req, io_out=0xAB40 one cycle after level=1, and it holds 5 cycles.
- Push 0xAB40, 0xAB41, 0xAB51 back-to-back with hold=10 → io_out shows exactly that sequence, each word for 11 cycles, ending at 0xAB51 with level=0 and busy=0.
- enable=0, push 9 words → level=8, 9th push sets overflow=1 and ack does not toggle; then clear=1 → level=0, overflow=0, io_out unchanged.
- FIFO full with enable=1, push in the same cycle as a pop → push rejected (overflow=1), level=7 after that cycle.
- la_oenb[16]=1 while toggling la_data_in[16] → no push, ack static. la_oenb[15:0]=FFFF → pushed word reads as 0x0000.
- Assert wb_rst_i mid-HOLD with 3 words queued → next cycle io_out=0, level=0, io_oeb=FFFF. After release, io_oeb=0000 and no stale word is displayed.

Source files
------------

// File: rtl/la_checkbit_sequencer_if.sv
// Firmware-facing bundle: the LA bank in both directions plus the mprj_io[31:16] pins.
// The master drives the LA inputs; the slave is the sequencer.
interface la_checkbit_sequencer_if #(
    parameter int WORD_W = 16
);
    logic [31:0]       la_data_in;
    logic [31:0]       la_oenb;
    logic [31:0]       la_data_out;
    logic [WORD_W-1:0] io_out;
    logic [WORD_W-1:0] io_oeb;

    modport master (
        output la_data_in, la_oenb,
        input  la_data_out, io_out, io_oeb
    );

    modport slave (
        input  la_data_in, la_oenb,
        output la_data_out, io_out, io_oeb
    );
endinterface

// File: rtl/la_checkbit_sequencer.sv
// Buffers firmware check words pushed over a toggle handshake and shows each one on
// mprj_io[31:16] for a programmable number of clocks.
module la_checkbit_sequencer #(
    parameter int DEPTH  = 8,
    parameter int WORD_W = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    la_checkbit_sequencer_if.slave   la
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {IDLE, HOLD} state_t;

    logic [26:0]       inR_q;
    logic              reqPrev_q;
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] ioOut_q, ioOut_d;
    logic [WORD_W-1:0] ioOeb_q;
    logic              ack_q, ack_d, ovf_q, ovf_d, busy_q;
    state_t            state_q, state_d;
    logic [7:0]        holdCnt_q, holdCnt_d;

    logic [WORD_W-1:0] rWord;
    logic              rReq, rEn, rClr;
    logic [7:0]        rHold;
    logic              pushReq, pushOk, popOk, full;
    logic [3:0]        levelRep;
    logic              unused_ok;

    assign rWord = inR_q[WORD_W-1:0];
    assign rReq  = inR_q[16];
    assign rHold = inR_q[24:17];
    assign rEn   = inR_q[25];
    assign rClr  = inR_q[26];

    // Full and empty are judged on the level at cycle start, so a pop never frees room for a same-cycle push.
    always_comb begin
        pushReq   = (rReq != reqPrev_q);
        full      = (level_q == LVL_W'(DEPTH));
        pushOk    = pushReq && !full && !rClr;
        popOk     = (state_q == IDLE) && rEn && (level_q != '0) && !rClr;

        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        level_d   = level_q;
        ack_d     = ack_q;
        ovf_d     = ovf_q;
        state_d   = state_q;
        holdCnt_d = holdCnt_q;
        ioOut_d   = ioOut_q;

        if (rClr) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            level_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (pushOk) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
                ack_d   = ~ack_q;
            end
            if (pushReq && full) begin
                ovf_d = 1'b1;
            end
            if (popOk) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            level_d = level_q + LVL_W'(pushOk) - LVL_W'(popOk);
        end

        case (state_q)
            IDLE: begin
                if (popOk) begin
                    state_d   = HOLD;
                    ioOut_d   = mem_q[rdPtr_q];
                    holdCnt_d = (rHold == 8'd0) ? 8'd0 : rHold - 8'd1;
                end
            end
            HOLD: begin
                if (holdCnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    holdCnt_d = holdCnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            inR_q     <= '0;
            reqPrev_q <= 1'b0;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            level_q   <= '0;
            ack_q     <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
            holdCnt_q <= '0;
            ioOut_q   <= '0;
            ioOeb_q   <= '1;
        end else begin
            inR_q     <= la.la_data_in[26:0] & ~la.la_oenb[26:0];
            reqPrev_q <= rReq;
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            level_q   <= level_d;
            ack_q     <= ack_d;
            ovf_q     <= ovf_d;
            busy_q    <= (state_d == HOLD) || (level_d != '0);
            state_q   <= state_d;
            holdCnt_q <= holdCnt_d;
            ioOut_q   <= ioOut_d;
            ioOeb_q   <= '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i && pushOk) begin
            mem_q[wrPtr_q] <= rWord;
        end
    end

    assign levelRep       = 4'(level_q);
    assign la.io_out      = ioOut_q;
    assign la.io_oeb      = ioOeb_q;
    assign la.la_data_out = {9'd0, busy_q, ovf_q, levelRep, ack_q, ioOut_q};

    assign unused_ok = ^{la.la_data_in[31:27], la.la_oenb[31:27]};

endmodule

// File: tb/tb_la_checkbit_sequencer.sv
// Directed bench for la_checkbit_sequencer: firmware-style pushes over the LA toggle
// handshake, with each scenario checking its own hand-computed expectations.
module tb_la_checkbit_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    la_checkbit_sequencer_if #(.WORD_W(16)) busIf ();

    la_checkbit_sequencer #(.DEPTH(8), .WORD_W(16)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .la       (busIf)
    );

    int checks = 0;
    int errors = 0;

    logic        reqBit = 1'b0;
    logic        en     = 1'b0;
    logic        clr    = 1'b0;
    logic [7:0]  hold   = 8'd0;
    logic [15:0] word   = 16'd0;
    logic        expAck = 1'b0;

    logic       ackOut, ovfOut, busyOut;
    logic [3:0] levelOut;
    assign ackOut   = busIf.la_data_out[16];
    assign levelOut = busIf.la_data_out[20:17];
    assign ovfOut   = busIf.la_data_out[21];
    assign busyOut  = busIf.la_data_out[22];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive();
        busIf.la_data_in = {5'd0, clr, en, hold, reqBit, word};
    endtask

    task automatic pushWord(input logic [15:0] w);
        word   = w;
        reqBit = ~reqBit;
        drive();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        busIf.la_oenb = 32'd0;
        reqBit = 1'b0; en = 1'b0; clr = 1'b0; hold = 8'd0; word = 16'd0;
        drive();
        tick(2);
        checks++; if (busIf.io_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_io_out got=%h exp=0000", busIf.io_out); end
        checks++; if (busIf.io_oeb !== 16'hFFFF) begin errors++; $display("[TB] FAIL reset_io_oeb got=%h exp=FFFF", busIf.io_oeb); end
        checks++; if (busIf.la_data_out !== 32'd0) begin errors++; $display("[TB] FAIL reset_la_out got=%h exp=0", busIf.la_data_out); end
        rst = 1'b0;
        tick(1);
        checks++; if (busIf.io_oeb !== 16'h0000) begin errors++; $display("[TB] FAIL release_io_oeb got=%h exp=0000", busIf.io_oeb); end
        checks++; if (busIf.la_data_out !== 32'd0) begin errors++; $display("[TB] FAIL release_la_out got=%h exp=0", busIf.la_data_out); end
    endtask

    task automatic test_single_push();
        en = 1'b1; hold = 8'd4;
        pushWord(16'hAB40);
        expAck = ~expAck;
        tick(1);
        checks++; if (ackOut !== ~expAck) begin errors++; $display("[TB] FAIL ack_early got=%b exp=%b", ackOut, ~expAck); end
        tick(1);
        checks++; if (ackOut !== expAck) begin errors++; $display("[TB] FAIL ack_latency got=%b exp=%b", ackOut, expAck); end
        checks++; if (levelOut !== 4'd1) begin errors++; $display("[TB] FAIL level_one got=%0d exp=1", levelOut); end
        checks++; if (busIf.io_out !== 16'h0000) begin errors++; $display("[TB] FAIL io_before_pop got=%h exp=0000", busIf.io_out); end
        tick(1);
        checks++; if (busIf.io_out !== 16'hAB40) begin errors++; $display("[TB] FAIL pop_value got=%h exp=AB40", busIf.io_out); end
        checks++; if (levelOut !== 4'd0) begin errors++; $display("[TB] FAIL level_after_pop got=%0d exp=0", levelOut); end
        checks++; if (busyOut !== 1'b1) begin errors++; $display("[TB] FAIL busy_in_hold got=%b exp=1", busyOut); end
        tick(3);
        checks++; if (busyOut !== 1'b1) begin errors++; $display("[TB] FAIL busy_last_hold got=%b exp=1", busyOut); end
        tick(1);
        checks++; if (busyOut !== 1'b0) begin errors++; $display("[TB] FAIL busy_hold_end got=%b exp=0", busyOut); end
        checks++; if (busIf.io_out !== 16'hAB40) begin errors++; $display("[TB] FAIL io_kept got=%h exp=AB40", busIf.io_out); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] expWord;
        hold = 8'd10;
        pushWord(16'hAB40); tick(1);
        pushWord(16'hAB41); tick(1);
        pushWord(16'hAB51); tick(1);
        expAck = ~expAck;
        // First pop lands 3 edges after the first drive; each word then stays 11 cycles.
        for (int k = 3; k <= 35; k++) begin
            expWord = (k < 14) ? 16'hAB40 : (k < 25) ? 16'hAB41 : 16'hAB51;
            checks++; if (busIf.io_out !== expWord) begin errors++; $display("[TB] FAIL seq_word cycle=%0d got=%h exp=%h", k, busIf.io_out, expWord); end
            if (k == 34) begin
                checks++; if (busyOut !== 1'b1) begin errors++; $display("[TB] FAIL seq_busy_last got=%b exp=1", busyOut); end
            end
            if (k != 35) tick(1);
        end
        checks++; if (busyOut !== 1'b0) begin errors++; $display("[TB] FAIL seq_busy_end got=%b exp=0", busyOut); end
        checks++; if (levelOut !== 4'd0) begin errors++; $display("[TB] FAIL seq_level_end got=%0d exp=0", levelOut); end
        checks++; if (ackOut !== expAck) begin errors++; $display("[TB] FAIL seq_ack got=%b exp=%b", ackOut, expAck); end
    endtask

    task automatic test_overflow();
        en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            pushWord(16'h1000 + 16'(i));
            tick(1);
        end
        checks++; if (levelOut !== 4'd8) begin errors++; $display("[TB] FAIL full_level got=%0d exp=8", levelOut); end
        checks++; if (ovfOut !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early got=%b exp=0", ovfOut); end
        tick(1);
        checks++; if (ovfOut !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got=%b exp=1", ovfOut); end
        checks++; if (levelOut !== 4'd8) begin errors++; $display("[TB] FAIL ovf_level got=%0d exp=8", levelOut); end
        checks++; if (ackOut !== expAck) begin errors++; $display("[TB] FAIL ovf_ack got=%b exp=%b", ackOut, expAck); end
        checks++; if (busyOut !== 1'b1) begin errors++; $display("[TB] FAIL ovf_busy got=%b exp=1", busyOut); end
        clr = 1'b1; drive(); tick(2);
        checks++; if (levelOut !== 4'd0) begin errors++; $display("[TB] FAIL clr_level got=%0d exp=0", levelOut); end
        checks++; if (ovfOut !== 1'b0) begin errors++; $display("[TB] FAIL clr_ovf got=%b exp=0", ovfOut); end
        checks++; if (busIf.io_out !== 16'hAB51) begin errors++; $display("[TB] FAIL clr_io got=%h exp=AB51", busIf.io_out); end
        checks++; if (ackOut !== expAck) begin errors++; $display("[TB] FAIL clr_ack got=%b exp=%b", ackOut, expAck); end
        clr = 1'b0; drive(); tick(1);
    endtask

    task automatic test_full_pop();
        en = 1'b0; hold = 8'd0;
        for (int i = 0; i < 8; i++) begin
            pushWord(16'hC000 + 16'(i));
            tick(1);
        end
        tick(1);
        checks++; if (levelOut !== 4'd8) begin errors++; $display("[TB] FAIL fp_level_full got=%0d exp=8", levelOut); end
        en = 1'b1;
        pushWord(16'hDEAD);
        tick(2);
        checks++; if (levelOut !== 4'd7) begin errors++; $display("[TB] FAIL fp_level got=%0d exp=7", levelOut); end
        checks++; if (ovfOut !== 1'b1) begin errors++; $display("[TB] FAIL fp_ovf got=%b exp=1", ovfOut); end
        checks++; if (ackOut !== expAck) begin errors++; $display("[TB] FAIL fp_ack got=%b exp=%b", ackOut, expAck); end
        checks++; if (busIf.io_out !== 16'hC000) begin errors++; $display("[TB] FAIL fp_io got=%h exp=C000", busIf.io_out); end
        en = 1'b0; clr = 1'b1; drive(); tick(2);
        clr = 1'b0; drive(); tick(1);
        checks++; if (levelOut !== 4'd0) begin errors++; $display("[TB] FAIL fp_flush got=%0d exp=0", levelOut); end
    endtask

    task automatic test_oenb();
        busIf.la_oenb = 32'h0001_0000;
        for (int i = 0; i < 4; i++) begin
            pushWord(16'h7777);
            tick(1);
        end
        tick(2);
        checks++; if (ackOut !== expAck) begin errors++; $display("[TB] FAIL oenb_ack got=%b exp=%b", ackOut, expAck); end
        checks++; if (levelOut !== 4'd0) begin errors++; $display("[TB] FAIL oenb_level got=%0d exp=0", levelOut); end
        busIf.la_oenb = 32'h0000_FFFF;
        en = 1'b1; hold = 8'd2;
        pushWord(16'h1234);
        expAck = ~expAck;
        tick(2);
        checks++; if (ackOut !== expAck) begin errors++; $display("[TB] FAIL oenb_push_ack got=%b exp=%b", ackOut, expAck); end
        tick(1);
        checks++; if (busIf.io_out !== 16'h0000) begin errors++; $display("[TB] FAIL oenb_word got=%h exp=0000", busIf.io_out); end
        checks++; if (busIf.la_data_out[15:0] !== 16'h0000) begin errors++; $display("[TB] FAIL oenb_mirror got=%h exp=0000", busIf.la_data_out[15:0]); end
        busIf.la_oenb = 32'd0;
        tick(3);
    endtask

    task automatic test_reset_mid_hold();
        en = 1'b1; hold = 8'd20;
        for (int i = 0; i < 4; i++) begin
            pushWord(16'h5001 + 16'(i));
            tick(1);
        end
        tick(1);
        checks++; if (levelOut !== 4'd3) begin errors++; $display("[TB] FAIL mid_level got=%0d exp=3", levelOut); end
        checks++; if (busIf.io_out !== 16'h5001) begin errors++; $display("[TB] FAIL mid_io got=%h exp=5001", busIf.io_out); end
        rst = 1'b1;
        reqBit = 1'b0; en = 1'b0; hold = 8'd0; word = 16'd0;
        drive();
        expAck = 1'b0;
        tick(1);
        checks++; if (busIf.io_out !== 16'h0000) begin errors++; $display("[TB] FAIL rst_io got=%h exp=0000", busIf.io_out); end
        checks++; if (busIf.la_data_out !== 32'd0) begin errors++; $display("[TB] FAIL rst_la_out got=%h exp=0", busIf.la_data_out); end
        checks++; if (busIf.io_oeb !== 16'hFFFF) begin errors++; $display("[TB] FAIL rst_oeb got=%h exp=FFFF", busIf.io_oeb); end
        rst = 1'b0;
        tick(1);
        checks++; if (busIf.io_oeb !== 16'h0000) begin errors++; $display("[TB] FAIL rel_oeb got=%h exp=0000", busIf.io_oeb); end
        en = 1'b1; drive();
        tick(4);
        checks++; if (busIf.io_out !== 16'h0000) begin errors++; $display("[TB] FAIL rel_no_stale got=%h exp=0000", busIf.io_out); end
        checks++; if (levelOut !== 4'd0) begin errors++; $display("[TB] FAIL rel_level got=%0d exp=0", levelOut); end
        checks++; if (busyOut !== 1'b0) begin errors++; $display("[TB] FAIL rel_busy got=%b exp=0", busyOut); end
        checks++; if (ackOut !== expAck) begin errors++; $display("[TB] FAIL rel_ack got=%b exp=%b", ackOut, expAck); end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_oenb();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule
